// File: rtl/irsram_pkg.sv
// Shared types and constants for the IRSRAM ping-pong controller.
// Build option: IRSRAM_LANE_MASK_EN enables per-lane write masking in the top.
package irsram_pkg;

    localparam int unsigned IR_ADDR_W = 7;
    localparam int unsigned IR_DEPTH  = 128;
    localparam int unsigned IR_LANE_W = 16;
    // One extra bit so a completely filled bank (128 words) is representable.
    localparam int unsigned IR_LEN_W  = IR_ADDR_W + 1;

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StFilling = 2'd1,
        StFull    = 2'd2
    } bank_state_e;

    // Word count of a fill whose final beat landed at addr.
    function automatic logic [IR_LEN_W-1:0] fill_len_of(input logic [IR_ADDR_W-1:0] addr);
        return {1'b0, addr} + IR_LEN_W'(1);
    endfunction

endpackage

// File: rtl/irsram_bank_fsm.sv
// Per-bank occupancy tracker: EMPTY -> FILLING -> FULL -> EMPTY, plus the
// length of the most recent completed fill.
module irsram_bank_fsm
    import irsram_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 fill_beat,   // accepted write beat targets this bank
    input  logic                 fill_last,   // that beat completes the fill
    input  logic [IR_ADDR_W-1:0] fill_addr,   // address of that beat
    input  logic                 rd_release,  // consumer frees this bank (already FULL-qualified)
    output bank_state_e          state,
    output logic [IR_LEN_W-1:0]  fill_len
);

    bank_state_e           state_q, state_d;
    logic [IR_LEN_W-1:0]   fill_len_q, fill_len_d;

    // State and fill length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            fill_len_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_len_q <= fill_len_d;
        end
    end

    // Next-state: flush wins, otherwise advance on fill beats and release.
    always_comb begin
        state_d    = state_q;
        fill_len_d = fill_len_q;
        if (flush) begin
            state_d    = StEmpty;
            fill_len_d = '0;
        end else begin
            unique case (state_q)
                StEmpty, StFilling: begin
                    if (fill_beat) begin
                        if (fill_last) begin
                            state_d    = StFull;
                            fill_len_d = fill_len_of(fill_addr);
                        end else begin
                            state_d = StFilling;
                        end
                    end
                end
                StFull: begin
                    if (rd_release) begin
                        state_d = StEmpty;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    assign state    = state_q;
    assign fill_len = fill_len_q;

endmodule

// File: rtl/irsram_pingpong_ctrl.sv
// Ping-pong controller for IRSRAM banks 1 and 2: the producer fills one bank
// while the consumer reads the other; roles swap on fill completion / release.
// Owns all SRAM pins and returns the read bank's Q with one cycle of latency.
// Build option: IRSRAM_LANE_MASK_EN adds wr_mask (per-lane write enable).
module irsram_pingpong_ctrl
    import irsram_pkg::*;
#(
    parameter int unsigned SRAM_NUM = 8,
    parameter int unsigned DEPTH    = IR_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    // Producer
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [SRAM_NUM*IR_LANE_W-1:0]  wr_data,
    input  logic                           wr_last,
`ifdef IRSRAM_LANE_MASK_EN
    input  logic [SRAM_NUM-1:0]            wr_mask,
`endif
    // Consumer
    input  logic                           rd_en,
    output logic                           rd_ready,
    input  logic [IR_ADDR_W-1:0]           rd_addr,
    input  logic                           rd_done,
    output logic [IR_LEN_W-1:0]            rd_len,
    output logic                           rd_valid,
    output logic [SRAM_NUM*IR_LANE_W-1:0]  rd_data,
    output logic                           rd_err,
    // IRSRAM pins
    output logic                           CEN1_ir,
    output logic                           CEN2_ir,
    output logic [SRAM_NUM-1:0]            WEN1_ir,
    output logic [SRAM_NUM-1:0]            WEN2_ir,
    output logic [IR_ADDR_W-1:0]           A1_ir,
    output logic [IR_ADDR_W-1:0]           A2_ir,
    output logic [SRAM_NUM*IR_LANE_W-1:0]  D1_ir,
    output logic [SRAM_NUM*IR_LANE_W-1:0]  D2_ir,
    input  logic [SRAM_NUM*IR_LANE_W-1:0]  Q1_ir,
    input  logic [SRAM_NUM*IR_LANE_W-1:0]  Q2_ir
);

    localparam int unsigned DataW = SRAM_NUM * IR_LANE_W;
    localparam logic [IR_ADDR_W-1:0] LastAddr = IR_ADDR_W'(DEPTH - 1);

    // Bank pointers: 0 = irsram1, 1 = irsram2.
    logic                 wbank_q, rbank_q;
    logic [IR_ADDR_W-1:0] wr_addr_q;
    logic                 rd_valid_q, rd_bank_q, rd_err_q;

    bank_state_e          bank_state [2];
    logic [IR_LEN_W-1:0]  bank_len   [2];

    logic                 wr_fire, wr_full;
    logic                 rd_issue, rd_release, rd_err_d;
    logic [SRAM_NUM-1:0]  wr_wen;

`ifdef IRSRAM_LANE_MASK_EN
    assign wr_wen = ~wr_mask;
`else
    assign wr_wen = '0;
`endif

    // Handshakes; flush suppresses every same-cycle request.
    assign wr_ready   = (bank_state[wbank_q] != StFull);
    assign wr_fire    = wr_valid & wr_ready & ~flush;
    assign wr_full    = wr_fire & (wr_last | (wr_addr_q == LastAddr));

    assign rd_ready   = (bank_state[rbank_q] == StFull);
    assign rd_len     = rd_ready ? bank_len[rbank_q] : '0;
    // rd_len is 0 when not ready, so the range check also covers that case.
    assign rd_issue   = rd_en & ~flush & ({1'b0, rd_addr} < rd_len);
    assign rd_err_d   = rd_en & ~flush & ({1'b0, rd_addr} >= rd_len);
    assign rd_release = rd_done & rd_ready & ~flush;

    irsram_bank_fsm u_bank1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fill_beat  (wr_fire & (wbank_q == 1'b0)),
        .fill_last  (wr_full),
        .fill_addr  (wr_addr_q),
        .rd_release (rd_release & (rbank_q == 1'b0)),
        .state      (bank_state[0]),
        .fill_len   (bank_len[0])
    );

    irsram_bank_fsm u_bank2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fill_beat  (wr_fire & (wbank_q == 1'b1)),
        .fill_last  (wr_full),
        .fill_addr  (wr_addr_q),
        .rd_release (rd_release & (rbank_q == 1'b1)),
        .state      (bank_state[1]),
        .fill_len   (bank_len[1])
    );

    // Pointers and write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            wr_addr_q <= '0;
        end else if (flush) begin
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            if (wr_full) begin
                wbank_q   <= ~wbank_q;
                wr_addr_q <= '0;
            end else if (wr_fire) begin
                wr_addr_q <= wr_addr_q + IR_ADDR_W'(1);
            end
            if (rd_release) begin
                rbank_q <= ~rbank_q;
            end
        end
    end

    // Read pipeline: remember which bank was issued so a same-cycle swap is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_issue;
            rd_err_q   <= rd_err_d;
            if (rd_issue) begin
                rd_bank_q <= rbank_q;
            end
        end
    end

    // A read still in flight when flush arrives is dropped.
    assign rd_valid = rd_valid_q & ~flush;
    assign rd_data  = rd_valid ? (rd_bank_q ? Q2_ir : Q1_ir) : '0;
    assign rd_err   = rd_err_q;

    logic                 cen  [2];
    logic [SRAM_NUM-1:0]  wen  [2];
    logic [IR_ADDR_W-1:0] addr [2];
    logic [DataW-1:0]     din  [2];

    // Pin mux: idle by default; the write and read banks never coincide.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            cen[b]  = 1'b1;
            wen[b]  = '1;
            addr[b] = '0;
            din[b]  = '0;
        end
        if (wr_fire) begin
            cen[wbank_q]  = 1'b0;
            wen[wbank_q]  = wr_wen;
            addr[wbank_q] = wr_addr_q;
            din[wbank_q]  = wr_data;
        end
        if (rd_issue) begin
            cen[rbank_q]  = 1'b0;
            wen[rbank_q]  = '1;
            addr[rbank_q] = rd_addr;
        end
    end

    assign CEN1_ir = cen[0];
    assign CEN2_ir = cen[1];
    assign WEN1_ir = wen[0];
    assign WEN2_ir = wen[1];
    assign A1_ir   = addr[0];
    assign A2_ir   = addr[1];
    assign D1_ir   = din[0];
    assign D2_ir   = din[1];

endmodule

// File: tb/tb_irsram_pingpong_ctrl.sv
// Directed bench for irsram_pingpong_ctrl with behavioural SRAM models on both banks.
module tb_irsram_pingpong_ctrl;

    localparam int unsigned N = 8;
    localparam int unsigned W = N * 16;

    logic          clk = 1'b0;
    logic          rst_n, flush;
    logic          wr_valid, wr_ready, wr_last;
    logic [W-1:0]  wr_data;
    logic          rd_en, rd_ready, rd_done, rd_valid, rd_err;
    logic [6:0]    rd_addr;
    logic [7:0]    rd_len;
    logic [W-1:0]  rd_data;
    logic          CEN1_ir, CEN2_ir;
    logic [N-1:0]  WEN1_ir, WEN2_ir;
    logic [6:0]    A1_ir, A2_ir;
    logic [W-1:0]  D1_ir, D2_ir;
    logic [W-1:0]  Q1_ir = '0;
    logic [W-1:0]  Q2_ir = '0;
`ifdef IRSRAM_LANE_MASK_EN
    logic [N-1:0]  wr_mask = '1;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mem1 [128];
    logic [W-1:0] mem2 [128];

    always #5 clk = ~clk;

    irsram_pingpong_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
`ifdef IRSRAM_LANE_MASK_EN
        .wr_mask  (wr_mask),
`endif
        .rd_en    (rd_en),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .rd_done  (rd_done),
        .rd_len   (rd_len),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .CEN1_ir  (CEN1_ir),
        .CEN2_ir  (CEN2_ir),
        .WEN1_ir  (WEN1_ir),
        .WEN2_ir  (WEN2_ir),
        .A1_ir    (A1_ir),
        .A2_ir    (A2_ir),
        .D1_ir    (D1_ir),
        .D2_ir    (D2_ir),
        .Q1_ir    (Q1_ir),
        .Q2_ir    (Q2_ir)
    );

    // SRAM models: per-lane write when WEN bit low, read when all WEN high.
    always @(posedge clk) begin
        if (!CEN1_ir) begin
            for (int l = 0; l < N; l++)
                if (!WEN1_ir[l]) mem1[A1_ir][l*16 +: 16] <= D1_ir[l*16 +: 16];
            if (&WEN1_ir) Q1_ir <= mem1[A1_ir];
        end
        if (!CEN2_ir) begin
            for (int l = 0; l < N; l++)
                if (!WEN2_ir[l]) mem2[A2_ir][l*16 +: 16] <= D2_ir[l*16 +: 16];
            if (&WEN2_ir) Q2_ir <= mem2[A2_ir];
        end
    end

    function automatic logic [W-1:0] word(input int tag, input int idx);
        logic [7:0] t8, i8;
        t8 = 8'(tag);
        i8 = 8'(idx);
        return {N{i8, t8}};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        // Reset state
        chk("rst_wr_ready", W'(wr_ready), W'(1));
        chk("rst_rd_ready", W'(rd_ready), W'(0));
        chk("rst_rd_len",   W'(rd_len),   W'(0));
        chk("rst_rd_valid", W'(rd_valid), W'(0));
        chk("rst_rd_data",  rd_data,      '0);
        chk("rst_rd_err",   W'(rd_err),   W'(0));
        chk("rst_cen",      W'({CEN1_ir, CEN2_ir}), W'(2'b11));
        chk("rst_wen",      W'({WEN1_ir, WEN2_ir}), W'(16'hffff));
        chk("rst_addr",     W'({A1_ir, A2_ir}), W'(0));
        chk("rst_din",      D1_ir | D2_ir, '0);
        rst_n = 1'b1;
        tick();

        // Fill bank1 with 5 beats
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = word(1, i); wr_last = (i == 4);
            #1;
            chk("fill5_cen1", W'(CEN1_ir), W'(0));
            chk("fill5_a1",   W'(A1_ir),   W'(i));
            chk("fill5_wen1", W'(WEN1_ir), W'(0));
            chk("fill5_d1",   D1_ir,       word(1, i));
            chk("fill5_cen2", W'(CEN2_ir), W'(1));
            tick();
        end
        idle_inputs();
        #1;
        chk("fill5_rd_len",   W'(rd_len),   W'(5));
        chk("fill5_rd_ready", W'(rd_ready), W'(1));
        chk("fill5_wr_ready", W'(wr_ready), W'(1));

        // Read address 3
        rd_en = 1'b1; rd_addr = 7'd3;
        #1;
        chk("rd3_cen1", W'(CEN1_ir), W'(0));
        chk("rd3_a1",   W'(A1_ir),   W'(3));
        chk("rd3_wen1", W'(WEN1_ir), W'(8'hff));
        tick();
        idle_inputs();
        #1;
        chk("rd3_valid", W'(rd_valid), W'(1));
        chk("rd3_data",  rd_data,      word(1, 3));
        chk("rd3_err",   W'(rd_err),   W'(0));
        tick();
        chk("rd3_valid_drop", W'(rd_valid), W'(0));

        // Out-of-range read
        rd_en = 1'b1; rd_addr = 7'd5;
        #1;
        chk("oor_cen1", W'(CEN1_ir), W'(1));
        tick();
        idle_inputs();
        #1;
        chk("oor_err",   W'(rd_err),   W'(1));
        chk("oor_valid", W'(rd_valid), W'(0));
        tick();
        chk("oor_err_pulse", W'(rd_err), W'(0));

        // Concurrent fill of bank2 and reads of bank1; release on last cycle
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_data = word(2, i); wr_last = (i == 5);
            rd_en = 1'b1; rd_addr = 7'(i % 5); rd_done = (i == 5);
            #1;
            chk("cc_cen2", W'(CEN2_ir), W'(0));
            chk("cc_a2",   W'(A2_ir),   W'(i));
            chk("cc_cen1", W'(CEN1_ir), W'(0));
            chk("cc_a1",   W'(A1_ir),   W'(i % 5));
            if (i > 0) chk("cc_rdata", rd_data, word(1, (i - 1) % 5));
            tick();
        end
        idle_inputs();
        #1;
        chk("cc_last_valid", W'(rd_valid), W'(1));
        chk("cc_last_data",  rd_data,      word(1, 0));
        chk("cc_rd_len",     W'(rd_len),   W'(6));
        chk("cc_wr_ready",   W'(wr_ready), W'(1));
        rd_en = 1'b1; rd_addr = 7'd5;
        #1;
        chk("cc_rd2_cen2", W'(CEN2_ir), W'(0));
        chk("cc_rd2_a2",   W'(A2_ir),   W'(5));
        tick();
        idle_inputs();
        #1;
        chk("cc_rd2_data", rd_data, word(2, 5));

        // 128-beat fill of bank1 without wr_last
        for (int i = 0; i < 128; i++) begin
            wr_valid = 1'b1; wr_data = word(1, i); wr_last = 1'b0;
            #1;
            if (i == 127) begin
                chk("f128_ready", W'(wr_ready), W'(1));
                chk("f128_a1",    W'(A1_ir),    W'(127));
                chk("f128_cen1",  W'(CEN1_ir),  W'(0));
            end
            tick();
        end
        idle_inputs();
        #1;
        chk("both_full_wr_ready", W'(wr_ready), W'(0));
        chk("both_full_rd_len",   W'(rd_len),   W'(6));
        rd_done = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("f128_rd_len",   W'(rd_len),   W'(128));
        chk("f128_wr_ready", W'(wr_ready), W'(1));
        rd_en = 1'b1; rd_addr = 7'd127;
        tick();
        idle_inputs();
        #1;
        chk("f128_rd127", rd_data, word(1, 127));

        // Flush mid-fill (bank2) and mid-read (bank1)
        wr_valid = 1'b1; wr_data = word(3, 0);
        tick();
        wr_data = word(3, 1); rd_en = 1'b1; rd_addr = 7'd10;
        tick();
        flush = 1'b1; wr_data = word(3, 2); rd_en = 1'b1; rd_addr = 7'd0;
        #1;
        chk("fl_cen", W'({CEN1_ir, CEN2_ir}), W'(2'b11));
        chk("fl_valid_suppr", W'(rd_valid), W'(0));
        chk("fl_data_zero",   rd_data,      '0);
        tick();
        idle_inputs();
        #1;
        chk("fl_rd_ready", W'(rd_ready), W'(0));
        chk("fl_rd_len",   W'(rd_len),   W'(0));
        chk("fl_wr_ready", W'(wr_ready), W'(1));
        chk("fl_rd_valid", W'(rd_valid), W'(0));
        chk("fl_rd_err",   W'(rd_err),   W'(0));

        // After flush: writes restart at bank1 address 0
        wr_valid = 1'b1; wr_data = word(4, 9); wr_last = 1'b1;
        #1;
        chk("pf_cen1", W'(CEN1_ir), W'(0));
        chk("pf_a1",   W'(A1_ir),   W'(0));
        chk("pf_cen2", W'(CEN2_ir), W'(1));
        tick();
        idle_inputs();
        #1;
        chk("pf_rd_len", W'(rd_len), W'(1));
        rd_en = 1'b1; rd_addr = 7'd0;
        tick();
        idle_inputs();
        #1;
        chk("pf_rd_valid", W'(rd_valid), W'(1));
        chk("pf_rd_data",  rd_data,      word(4, 9));

        // Async reset while a read result is being presented
        rd_en = 1'b1; rd_addr = 7'd0;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("ar_rd_valid", W'(rd_valid), W'(0));
        chk("ar_rd_data",  rd_data,      '0);
        chk("ar_rd_ready", W'(rd_ready), W'(0));
        chk("ar_rd_len",   W'(rd_len),   W'(0));
        chk("ar_wr_ready", W'(wr_ready), W'(1));
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_post_cen", W'({CEN1_ir, CEN2_ir}), W'(2'b11));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
